if_id_skid_reg: RTL and testbench
=================================

// Module: if_id_skid_reg
// PURPOSE
//  Consumer end of the instruction-fetch interface: captures instruction/pc_plus_four from the fetch stage
//  and presents them to decode. A 2-entry skid buffer lets decode stall without a combinational ready path
//  back to fetch. Branch-taken (pc_src) flushes wrong-path words. Empty slots present a NOP (32'h0).
// PARAMETERS
//  DATA_W   32   width of instruction and pc_plus_four
//  CNT_W    16   width of saturating bubble/stall counters
// PORTS
//  clk              in   1       system clock; all state changes on rising edge
//  rst              in   1       synchronous, active-high reset
//  if_valid         in   1       fetch presents a valid word this cycle
//  if_instruction   in   DATA_W  fetched instruction
//  if_pc_plus_four  in   DATA_W  pc+4 of fetched instruction
//  if_ready         out  1       block can accept a word; fetch holds pc when low
//  pc_src           in   1       branch taken; flush all held words
//  id_valid         out  1       id_* outputs hold a valid word
//  id_instruction   out  DATA_W  instruction to decode (32'h0 when !id_valid)
//  id_pc_plus_four  out  DATA_W  pc+4 to decode (0 when !id_valid)
//  id_ready         in   1       decode consumes the word this cycle
//  bubble_count     out  CNT_W   cycles with id_ready=1 and id_valid=0, saturating
//  stall_count      out  CNT_W   cycles with if_valid=1 and if_ready=0, saturating
// BEHAVIOUR
//  - Reset (rst=1 at edge): state EMPTY; id_valid=0, id_instruction=0, id_pc_plus_four=0, skid cleared,
//    both counters=0; if_ready=1 in the cycle after reset. Reset mid-transfer discards all held words.
//  - Accept = if_valid & if_ready; consume = id_valid & id_ready. Throughput 1 word/cycle, latency 1 cycle
//    from accept to id_valid.
//  - if_ready is a pure function of registered state: if_ready = (state != FULL). No comb path from id_ready.
//  - States: EMPTY (no word), ONE (main reg valid), FULL (main + skid valid).
//    EMPTY: accept -> ONE (word into main).
//    ONE:   accept&consume -> ONE (new word into main); accept&!consume -> FULL (word into skid);
//           !accept&consume -> EMPTY; else hold.
//    FULL:  consume -> ONE (skid moves to main, skid cleared); else hold. No accept possible.
//  - Ordering: words leave in acceptance order; skid never overtakes main.
//  - Flush: pc_src=1 at edge -> state EMPTY, main and skid data cleared to 0, id_valid=0 next cycle.
//    Flush has priority over accept and consume in the same cycle; a word accepted in the flush cycle is
//    dropped (wrong path). A consume in the flush cycle still counts as delivered to decode.
//  - rst has priority over pc_src.
//  - Counters: increment by 1 per qualifying cycle, stick at 2^CNT_W-1; not cleared by flush, only by rst.
//  - Held data never changes while id_valid=1 and id_ready=0 (stable under stall).
// STRUCTURE
//  - Shared package cpu_pipe_pkg: NOP_INSTR = 32'h0000_0000; state encoding SK_EMPTY=2'd0, SK_ONE=2'd1,
//    SK_FULL=2'd2; DATA_W default 32.
//  - One sub-module: pipe_sat_counter (CNT_W param; inc, clear inputs; saturating), instantiated twice.
//  - Skid FSM and data registers stay in this module; flat, no further hierarchy.
// TESTING
//  1 Reset: rst=1 two cycles -> id_valid=0, id_instruction=0, if_ready=1, counters=0.
//  2 Streaming: if_valid=1 words 0x20100001..0x20100004, id_ready=1 -> same words on id_* one cycle later,
//    back-to-back, if_ready stays 1, bubble_count=1 (first cycle).
//  3 Stall/skid: id_ready=0 while sending 0xAAAA0001, 0xAAAA0002 -> FULL, if_ready=0, id_instruction
//    holds 0xAAAA0001; third word held by fetch, stall_count increments; id_ready=1 -> 0xAAAA0002 then
//    third word, no loss or duplication.
//  4 Flush in FULL: state FULL, pc_src=1 with if_valid=1 -> next cycle id_valid=0, id_instruction=0,
//    if_ready=1; neither held word nor flush-cycle word ever appears.
//  5 Reset mid-operation: state ONE with 0x12345678 held, rst=1 -> id_valid=0, data 0, counters 0.
//  6 Saturation: CNT_W=4, id_ready=1, if_valid=0 for 20 cycles -> bubble_count stops at 15.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline-register blocks.
package cpu_pipe_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts up on inc and sticks at all-ones.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: advance on inc unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer, branch flush and
// saturating bubble/stall counters. if_ready depends only on registered state.
module if_id_skid_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_instruction,
    input  logic [DATA_W-1:0] if_pc_plus_four,
    output logic              if_ready,
    input  logic              pc_src,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instruction,
    output logic [DATA_W-1:0] id_pc_plus_four,
    input  logic              id_ready,
    output logic [CNT_W-1:0]  bubble_count,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_INSTR);

    skid_state_e       state_q,      state_d;
    logic [DATA_W-1:0] main_instr_q, main_instr_d;
    logic [DATA_W-1:0] main_pc_q,    main_pc_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [DATA_W-1:0] skid_pc_q,    skid_pc_d;

    logic accept;
    logic consume;

    assign if_ready = (state_q != SK_FULL);
    assign id_valid = (state_q != SK_EMPTY);
    assign accept   = if_valid & if_ready;
    assign consume  = id_valid & id_ready;

    // Empty slots are always held at NOP, so the main register drives decode directly.
    assign id_instruction  = main_instr_q;
    assign id_pc_plus_four = main_pc_q;

    // Next-state and data movement; flush overrides everything else.
    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        case (state_q)
            SK_EMPTY: begin
                if (accept) begin
                    main_instr_d = if_instruction;
                    main_pc_d    = if_pc_plus_four;
                    state_d      = SK_ONE;
                end
            end
            SK_ONE: begin
                if (accept && consume) begin
                    main_instr_d = if_instruction;
                    main_pc_d    = if_pc_plus_four;
                end else if (accept) begin
                    skid_instr_d = if_instruction;
                    skid_pc_d    = if_pc_plus_four;
                    state_d      = SK_FULL;
                end else if (consume) begin
                    main_instr_d = NOP_W;
                    main_pc_d    = '0;
                    state_d      = SK_EMPTY;
                end
            end
            SK_FULL: begin
                if (consume) begin
                    main_instr_d = skid_instr_q;
                    main_pc_d    = skid_pc_q;
                    skid_instr_d = NOP_W;
                    skid_pc_d    = '0;
                    state_d      = SK_ONE;
                end
            end
            default: begin
                main_instr_d = NOP_W;
                main_pc_d    = '0;
                skid_instr_d = NOP_W;
                skid_pc_d    = '0;
                state_d      = SK_EMPTY;
            end
        endcase

        if (pc_src) begin
            main_instr_d = NOP_W;
            main_pc_d    = '0;
            skid_instr_d = NOP_W;
            skid_pc_d    = '0;
            state_d      = SK_EMPTY;
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SK_EMPTY;
            main_instr_q <= NOP_W;
            main_pc_q    <= '0;
            skid_instr_q <= NOP_W;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (id_ready & ~id_valid),
        .count (bubble_count)
    );

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (if_valid & ~if_ready),
        .count (stall_count)
    );

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: directed vector table, saturation sequence and
// randomized traffic against a queue-based reference model.
module tb_if_id_skid_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_valid;
    logic [DATA_W-1:0] if_instruction;
    logic [DATA_W-1:0] if_pc_plus_four;
    logic              if_ready;
    logic              pc_src;
    logic              id_valid;
    logic [DATA_W-1:0] id_instruction;
    logic [DATA_W-1:0] id_pc_plus_four;
    logic              id_ready;
    logic [CNT_W-1:0]  bubble_count;
    logic [CNT_W-1:0]  stall_count;

    int unsigned tests  = 0;
    int unsigned errors = 0;

    if_id_skid_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .if_valid        (if_valid),
        .if_instruction  (if_instruction),
        .if_pc_plus_four (if_pc_plus_four),
        .if_ready        (if_ready),
        .pc_src          (pc_src),
        .id_valid        (id_valid),
        .id_instruction  (id_instruction),
        .id_pc_plus_four (id_pc_plus_four),
        .id_ready        (id_ready),
        .bubble_count    (bubble_count),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ifv;
        logic [31:0] instr;
        logic        pcs;
        logic        idr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic        e_ready;
        int unsigned e_bub;
        int unsigned e_stl;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] ins,
                         input logic p, input logic d);
        rst             = r;
        if_valid        = v;
        if_instruction  = ins;
        if_pc_plus_four = ins + 32'd4;
        pc_src          = p;
        id_ready        = d;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] ei,
                             input logic [31:0] ep, input logic er,
                             input int unsigned eb, input int unsigned es);
        chk({tag, ".id_valid"},   32'(id_valid),        32'(ev));
        chk({tag, ".id_instr"},   id_instruction,       ei);
        chk({tag, ".id_pc"},      id_pc_plus_four,      ep);
        chk({tag, ".if_ready"},   32'(if_ready),        32'(er));
        chk({tag, ".bubble"},     32'(bubble_count),    32'(eb));
        chk({tag, ".stall"},      32'(stall_count),     32'(es));
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] ins,
                                input logic p, input logic d, input logic ev,
                                input logic [31:0] ei, input logic er,
                                input int unsigned eb, input int unsigned es);
        vec_t t;
        t.rst = r; t.ifv = v; t.instr = ins; t.pcs = p; t.idr = d;
        t.e_valid = ev; t.e_instr = ei; t.e_ready = er; t.e_bub = eb; t.e_stl = es;
        return t;
    endfunction

    // Reference model: an ordered queue of at most two words.
    logic [31:0] mq_i[$];
    logic [31:0] mq_p[$];
    int unsigned m_bub, m_stl;

    task automatic model_step(input logic r, input logic v, input logic [31:0] ins,
                              input logic [31:0] pcv, input logic p, input logic d);
        bit rdy, vld;
        rdy = (mq_i.size() < 2);
        vld = (mq_i.size() > 0);
        if (r) begin
            mq_i.delete(); mq_p.delete();
            m_bub = 0; m_stl = 0;
        end else begin
            if (d && !vld && m_bub < CMAX) m_bub++;
            if (v && !rdy && m_stl < CMAX) m_stl++;
            if (p) begin
                mq_i.delete(); mq_p.delete();
            end else begin
                if (d && vld) begin
                    void'(mq_i.pop_front()); void'(mq_p.pop_front());
                end
                if (v && rdy) begin
                    mq_i.push_back(ins); mq_p.push_back(pcv);
                end
            end
        end
    endtask

    initial begin
        logic [31:0] ri, rp;
        logic        rr, rv, rpc, rd;
        string       tag;

        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // reset
        vecs[0]  = mk(1,0,32'h0,       0,0, 0,32'h0,       1,0,0);
        vecs[1]  = mk(1,0,32'h0,       0,0, 0,32'h0,       1,0,0);
        // streaming
        vecs[2]  = mk(0,1,32'h20100001,0,1, 1,32'h20100001,1,1,0);
        vecs[3]  = mk(0,1,32'h20100002,0,1, 1,32'h20100002,1,1,0);
        vecs[4]  = mk(0,1,32'h20100003,0,1, 1,32'h20100003,1,1,0);
        vecs[5]  = mk(0,1,32'h20100004,0,1, 1,32'h20100004,1,1,0);
        vecs[6]  = mk(0,0,32'h0,       0,1, 0,32'h0,       1,1,0);
        // stall into skid, drain in order
        vecs[7]  = mk(0,1,32'hAAAA0001,0,0, 1,32'hAAAA0001,1,1,0);
        vecs[8]  = mk(0,1,32'hAAAA0002,0,0, 1,32'hAAAA0001,0,1,0);
        vecs[9]  = mk(0,1,32'hAAAA0003,0,0, 1,32'hAAAA0001,0,1,1);
        vecs[10] = mk(0,1,32'hAAAA0003,0,0, 1,32'hAAAA0001,0,1,2);
        vecs[11] = mk(0,1,32'hAAAA0003,0,1, 1,32'hAAAA0002,1,1,3);
        vecs[12] = mk(0,1,32'hAAAA0003,0,1, 1,32'hAAAA0003,1,1,3);
        vecs[13] = mk(0,0,32'h0,       0,1, 0,32'h0,       1,1,3);
        // flush while full, with a word offered in the flush cycle
        vecs[14] = mk(0,1,32'hBBBB0001,0,0, 1,32'hBBBB0001,1,1,3);
        vecs[15] = mk(0,1,32'hBBBB0002,0,0, 1,32'hBBBB0001,0,1,3);
        vecs[16] = mk(0,1,32'hBBBB0003,1,0, 0,32'h0,       1,1,4);
        vecs[17] = mk(0,0,32'h0,       0,1, 0,32'h0,       1,2,4);
        // reset while holding a word
        vecs[18] = mk(0,1,32'h12345678,0,0, 1,32'h12345678,1,2,4);
        vecs[19] = mk(1,0,32'h0,       0,0, 0,32'h0,       1,0,0);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst, vecs[i].ifv, vecs[i].instr, vecs[i].pcs, vecs[i].idr);
            @(posedge clk); #1;
            tag = $sformatf("vec%0d", i);
            check_all(tag, vecs[i].e_valid, vecs[i].e_instr,
                      vecs[i].e_valid ? vecs[i].e_instr + 32'd4 : 32'h0,
                      vecs[i].e_ready, vecs[i].e_bub, vecs[i].e_stl);
        end

        // bubble counter saturation
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            @(posedge clk); #1;
            chk($sformatf("sat%0d.bubble", i), 32'(bubble_count),
                (i + 1 < CMAX) ? 32'(i + 1) : 32'(CMAX));
        end
        chk("sat.stall", 32'(stall_count), 32'h0);

        // consume in the flush cycle: word delivered, nothing left afterwards
        drive(1'b0, 1'b1, 32'hCCCC0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'hCCCC0002, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("flush_consume.id_valid", 32'(id_valid), 32'h0);
        chk("flush_consume.id_instr", id_instruction, 32'h0);

        // randomized traffic against the model
        mq_i.delete(); mq_p.delete(); m_bub = 0; m_stl = 0;
        for (int n = 0; n < 3000; n++) begin
            rr  = (n == 0) || ($urandom_range(0, 99) == 0);
            rv  = ($urandom_range(0, 3) != 0);
            rpc = ($urandom_range(0, 15) == 0);
            rd  = ($urandom_range(0, 2) != 0);
            ri  = $urandom;
            rp  = $urandom;
            rst = rr; if_valid = rv; if_instruction = ri; if_pc_plus_four = rp;
            pc_src = rpc; id_ready = rd;
            model_step(rr, rv, ri, rp, rpc, rd);
            @(posedge clk); #1;
            tag = $sformatf("rnd%0d", n);
            check_all(tag, mq_i.size() > 0,
                      (mq_i.size() > 0) ? mq_i[0] : 32'h0,
                      (mq_p.size() > 0) ? mq_p[0] : 32'h0,
                      mq_i.size() < 2, m_bub, m_stl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
